psum_collector: RTL and testbench



---
 rtl/psum_pkg.sv | 18 +
 rtl/psum_collector_if.sv | 28 ++
 rtl/psum_lane.sv | 30 +++
 rtl/psum_collector.sv | 120 ++++++++++++
 tb/tb_psum_collector.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types, default geometry and sign-extension helper for the partial-sum collector.
package psum_pkg;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int O_DEF      = 32;
    localparam int K_DEF      = 22;
    localparam int ACC_W_DEF  = 32;
    localparam int TILE_W_DEF = 8;

    function automatic logic [ACC_W_DEF-1:0] sext(input logic [K_DEF-1:0] x);
        return {{(ACC_W_DEF-K_DEF){x[K_DEF-1]}}, x};
    endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Capture bus from the MAC array plus the valid/ready output stream toward writeback.
interface psum_collector_if #(
    parameter int O     = 32,
    parameter int K     = 22,
    parameter int ACC_W = 32
);
    localparam int IDX_W = $clog2(O);

    logic [K*O-1:0]   partial;
    logic [O-1:0]     vld;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output partial, vld, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  partial, vld, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/psum_lane.sv
// One signed accumulator lane: synchronous clear wins over add; sums wrap modulo 2^ACC_W.
module psum_lane
    import psum_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [K-1:0]     part_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_q + sext(part_i);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/psum_collector.sv
// Accumulates O lanes over num_tiles captures, then streams O sums one per handshake; capture
// stalls (in_ready=0) while draining, drain holds its word under out_ready=0. Macro: PSUM_RELU_EN.
module psum_collector
    import psum_pkg::*;
#(
    parameter int O      = O_DEF,
    parameter int K      = K_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int TILE_W = TILE_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [TILE_W-1:0] num_tiles,
    psum_collector_if.slave   bus,
    output logic              err_ovf,
    output logic              err_align
);

    localparam int IDX_W = $clog2(O);

    state_t            state_q, state_d;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [TILE_W-1:0] eff_tiles;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_align_q, err_align_d;
    logic              all_v, part_v, in_rdy, cap, clr;
    logic [ACC_W-1:0]  acc [O];
    logic [ACC_W-1:0]  acc_sel;

    assign all_v  = &bus.vld;
    assign part_v = (|bus.vld) && !all_v;
    assign in_rdy = (state_q == ST_ACC);
    assign cap    = all_v && in_rdy;

    // The tile count is only sampled on the first tile so mid-pixel changes are ignored.
    assign eff_tiles = (tile_cnt_q != '0)   ? tiles_q :
                       (num_tiles  == '0)   ? TILE_W'(1) : num_tiles;

    always_comb begin
        state_d     = state_q;
        tile_cnt_d  = tile_cnt_q;
        tiles_d     = tiles_q;
        idx_d       = idx_q;
        clr         = 1'b0;
        err_ovf_d   = err_ovf_q | (all_v && !in_rdy);
        err_align_d = err_align_q | part_v;
        case (state_q)
            ST_ACC: begin
                if (cap) begin
                    tiles_d = eff_tiles;
                    if (tile_cnt_q == eff_tiles - TILE_W'(1)) begin
                        tile_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (idx_q == IDX_W'(O-1)) begin
                        idx_d   = '0;
                        clr     = 1'b1;
                        state_d = ST_ACC;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ACC;
            tile_cnt_q  <= '0;
            tiles_q     <= '0;
            idx_q       <= '0;
            err_ovf_q   <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_cnt_q  <= tile_cnt_d;
            tiles_q     <= tiles_d;
            idx_q       <= idx_d;
            err_ovf_q   <= err_ovf_d;
            err_align_q <= err_align_d;
        end
    end

    for (genvar g = 0; g < O; g++) begin : g_lane
        psum_lane #(.K(K), .ACC_W(ACC_W)) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .clr_i  (clr),
            .add_i  (cap),
            .part_i (bus.partial[K*g +: K]),
            .acc_o  (acc[g])
        );
    end

    assign acc_sel = acc[idx_q];

`ifdef PSUM_RELU_EN
    assign bus.out_data = acc_sel[ACC_W-1] ? '0 : acc_sel;
`else
    assign bus.out_data = acc_sel;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == ST_DRAIN) && (idx_q == IDX_W'(O-1));
    assign err_ovf       = err_ovf_q;
    assign err_align     = err_align_q;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboarded bench for psum_collector: expected words queued at capture time, compared after drain.
module tb_psum_collector;

    localparam int O = 32;
    localparam int K = 22;
    localparam int ACC_W = 32;
    localparam int TILE_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [4:0]       i;
        logic             l;
    } word_t;

    logic              clk;
    logic              rstn;
    logic [TILE_W-1:0] num_tiles;
    logic              err_ovf;
    logic              err_align;

    psum_collector_if #(.O(O), .K(K), .ACC_W(ACC_W)) bus ();

    psum_collector dut (
        .clk       (clk),
        .rstn      (rstn),
        .num_tiles (num_tiles),
        .bus       (bus),
        .err_ovf   (err_ovf),
        .err_align (err_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    m [O];
    word_t exp_q [$];
    word_t got_q [$];

    task automatic do_reset();
        rstn = 1'b0;
        bus.vld = '0;
        bus.partial = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < O; i++) m[i] = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic capture(input int lane_v [O], input logic [O-1:0] v);
        logic [K-1:0]   t;
        logic [K*O-1:0] p;
        for (int i = 0; i < O; i++) begin
            t = lane_v[i][K-1:0];
            p[K*i +: K] = t;
        end
        @(negedge clk);
        bus.partial = p;
        bus.vld = v;
        @(negedge clk);
        bus.vld = '0;
    endtask

    task automatic model_add(input int lane_v [O]);
        for (int i = 0; i < O; i++) m[i] += lane_v[i];
    endtask

    task automatic push_exp();
        word_t w;
        int    v;
        for (int i = 0; i < O; i++) begin
            v = m[i];
`ifdef PSUM_RELU_EN
            if (v < 0) v = 0;
`endif
            w.d = v;
            w.i = 5'(i);
            w.l = (i == O-1);
            exp_q.push_back(w);
            m[i] = 0;
        end
    endtask

    task automatic drain(input bit stall, output int n_hs, output int n_unst,
                         output int n_inrdy, output bit timeout);
        word_t prev, cur;
        bit    pstall, done;
        n_hs = 0; n_unst = 0; n_inrdy = 0; pstall = 0; done = 0;
        prev = '0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            bus.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (bus.out_valid) begin
                cur.d = bus.out_data;
                cur.i = bus.out_idx;
                cur.l = bus.out_last;
                if (bus.in_ready) n_inrdy++;
                if (pstall && cur !== prev) n_unst++;
                prev = cur;
                pstall = !bus.out_ready;
                if (bus.out_ready) begin
                    got_q.push_back(cur);
                    n_hs++;
                    if (cur.l) done = 1;
                end
            end
        end
        timeout = !done;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.out_valid, bus.out_last, bus.out_idx, bus.out_data, err_ovf, err_align, bus.in_ready}
            !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: valid=%b last=%b idx=%0d data=%h ovf=%b align=%b in_rdy=%b",
                     bus.out_valid, bus.out_last, bus.out_idx, bus.out_data, err_ovf, err_align, bus.in_ready);
        end
    endtask

    task automatic test_accum3();
        int lv [O];
        int hs, un, ir;
        bit to;
        word_t e, w;
        for (int i = 0; i < O; i++) lv[i] = 'h10;
        num_tiles = 8'd3;
        capture(lv, '1); model_add(lv);
        num_tiles = 8'd1;
        capture(lv, '1); model_add(lv);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL accum3_early_drain: out_valid=%b want 0", bus.out_valid);
        end
        capture(lv, '1); model_add(lv);
        push_exp();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL accum3_latency: valid=%b idx=%0d in_rdy=%b want 1 0 0",
                     bus.out_valid, bus.out_idx, bus.in_ready);
        end
        drain(0, hs, un, ir, to);
        n_vec++;
        if (to || hs != O || ir != 0) begin
            n_err++; $display("FAIL accum3_drain: hs=%0d timeout=%0d in_rdy_cycles=%0d want %0d 0 0", hs, to, ir, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL accum3_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL accum3_word: got d=%h i=%0d l=%b want d=%h i=%0d l=%b", w.d, w.i, w.l, e.d, e.i, e.l);
                end
            end
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL accum3_in_ready_after: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_neg();
        int lv [O];
        int hs, un, ir;
        bit to;
        word_t e, w;
        for (int i = 0; i < O; i++) lv[i] = -(i + 1);
        num_tiles = 8'd1;
        capture(lv, '1); model_add(lv);
        push_exp();
        drain(0, hs, un, ir, to);
        n_vec++;
        if (to || hs != O) begin
            n_err++; $display("FAIL neg_drain: hs=%0d timeout=%0d want %0d 0", hs, to, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL neg_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL neg_word: got d=%h i=%0d want d=%h i=%0d", w.d, w.i, e.d, e.i);
                end
            end
        end
    endtask

    task automatic test_stall();
        int lv [O];
        int hs, un, ir;
        bit to;
        word_t e, w;
        for (int i = 0; i < O; i++) lv[i] = ((i * 37) % 200) - 100;
        num_tiles = 8'd2;
        capture(lv, '1); model_add(lv);
        capture(lv, '1); model_add(lv);
        push_exp();
        drain(1, hs, un, ir, to);
        n_vec++;
        if (to || hs != O || un != 0) begin
            n_err++; $display("FAIL stall_drain: hs=%0d timeout=%0d unstable=%0d want %0d 0 0", hs, to, un, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL stall_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL stall_word: got d=%h i=%0d l=%b want d=%h i=%0d l=%b", w.d, w.i, w.l, e.d, e.i, e.l);
                end
            end
        end
    endtask

    task automatic test_align();
        int lv [O];
        int hs, un, ir;
        bit to;
        word_t e, w;
        for (int i = 0; i < O; i++) lv[i] = 1000 + i;
        num_tiles = 8'd1;
        capture(lv, 32'h0000FFFF);
        n_vec++;
        if (err_align !== 1'b1 || bus.out_valid !== 1'b0 || err_ovf !== 1'b0) begin
            n_err++; $display("FAIL align_flag: align=%b valid=%b ovf=%b want 1 0 0", err_align, bus.out_valid, err_ovf);
        end
        for (int i = 0; i < O; i++) lv[i] = 7;
        capture(lv, '1); model_add(lv);
        push_exp();
        drain(0, hs, un, ir, to);
        n_vec++;
        if (to || hs != O) begin
            n_err++; $display("FAIL align_drain: hs=%0d timeout=%0d want %0d 0", hs, to, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL align_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL align_word: got d=%h i=%0d want d=%h i=%0d", w.d, w.i, e.d, e.i);
                end
            end
        end
    endtask

    task automatic test_ovf();
        int lv [O];
        int junk [O];
        int hs, un, ir;
        bit to;
        word_t e, w;
        for (int i = 0; i < O; i++) begin
            lv[i] = 100 + i;
            junk[i] = 5000;
        end
        num_tiles = 8'd1;
        capture(lv, '1); model_add(lv);
        push_exp();
        capture(junk, '1);
        n_vec++;
        if (err_ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_flag: got %b want 1", err_ovf);
        end
        drain(0, hs, un, ir, to);
        n_vec++;
        if (to || hs != O) begin
            n_err++; $display("FAIL ovf_drain: hs=%0d timeout=%0d want %0d 0", hs, to, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL ovf_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL ovf_word: got d=%h i=%0d want d=%h i=%0d", w.d, w.i, e.d, e.i);
                end
            end
        end
        do_reset();
        n_vec++;
        if ({err_ovf, err_align, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last}
            !== {1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_after_reset: ovf=%b align=%b valid=%b data=%h idx=%0d last=%b",
                     err_ovf, err_align, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
        end
    endtask

    task automatic test_zero_tiles_midreset();
        int lv [O];
        int hs, un, ir;
        bit to, hit;
        word_t e, w;
        for (int i = 0; i < O; i++) lv[i] = 50 + i;
        num_tiles = 8'd0;
        capture(lv, '1);
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL zero_tiles: out_valid=%b want 1 after one capture", bus.out_valid);
        end
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (bus.out_idx == 5'd10 && bus.out_valid) begin
                hit = 1;
            end else begin
                bus.out_ready = 1'b1;
                @(negedge clk);
            end
        end
        bus.out_ready = 1'b0;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (!hit || bus.out_valid !== 1'b0 || bus.out_idx !== 5'd0) begin
            n_err++; $display("FAIL midreset_abort: reached_idx10=%0d valid=%b idx=%0d want 1 0 0", hit, bus.out_valid, bus.out_idx);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < O; i++) m[i] = 0;
        for (int i = 0; i < O; i++) lv[i] = 2;
        num_tiles = 8'd1;
        capture(lv, '1); model_add(lv);
        push_exp();
        drain(0, hs, un, ir, to);
        n_vec++;
        if (to || hs != O) begin
            n_err++; $display("FAIL midreset_drain: hs=%0d timeout=%0d want %0d 0", hs, to, O);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL midreset_word: lane %0d missing", e.i);
            end else begin
                w = got_q.pop_front();
                if (w !== e) begin
                    n_err++; $display("FAIL midreset_word: got d=%h i=%0d want d=%h i=%0d", w.d, w.i, e.d, e.i);
                end
            end
        end
    endtask

    initial begin
        num_tiles = 8'd1;
        test_reset();
        test_accum3();
        test_neg();
        test_stall();
        test_align();
        test_ovf();
        test_zero_tiles_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
